jtag_tap_core: RTL and testbench

Parametrised successor to the team's bare TAP state machine. Adds the full IEEE 1149.1-style datapath on top of the 16-state TAP FSM: an instruction register, BYPASS, IDCODE and one user data register, plus TDO muxing. Sits between the JTAG pins and on-chip debug/config logic. The user DR is exported as a capture/update interface.

---
 rtl/jtag_tap_core.sv | 143 ++++++++++++++
 tb/tb_jtag_tap_core.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/jtag_tap_core.sv
// IEEE 1149.1-style TAP: 16-state controller, instruction register and
// BYPASS / IDCODE / user data registers with a capture/update user port.
module jtag_tap_core #(
    parameter int                  IR_WIDTH      = 4,
    parameter logic [31:0]         IDCODE_VALUE  = 32'h1234_5001,
    parameter int                  USER_DR_WIDTH = 8,
    parameter logic [IR_WIDTH-1:0] OPC_IDCODE    = IR_WIDTH'(1),
    parameter logic [IR_WIDTH-1:0] OPC_USER      = IR_WIDTH'(2)
) (
    input  logic                     TCK,
    input  logic                     TRST,
    input  logic                     TMS,
    input  logic                     TDI,
    output logic                     TDO,
    output logic                     TDO_EN,
    output logic [3:0]               STATE,
    output logic [IR_WIDTH-1:0]      IR_OUT,
    output logic                     USER_SEL,
    input  logic [USER_DR_WIDTH-1:0] USER_CAPTURE,
    output logic [USER_DR_WIDTH-1:0] USER_UPDATE,
    output logic                     USER_UPDATE_STB,
    output logic                     TLR,
    output logic                     RTI
);

    typedef enum logic [3:0] {
        ST_EX2DR = 4'h0, ST_EX1DR = 4'h1, ST_SHDR  = 4'h2, ST_PADR  = 4'h3,
        ST_SELIR = 4'h4, ST_UPDR  = 4'h5, ST_CAPDR = 4'h6, ST_SELDR = 4'h7,
        ST_EX2IR = 4'h8, ST_EX1IR = 4'h9, ST_SHIR  = 4'hA, ST_PAIR  = 4'hB,
        ST_RTI   = 4'hC, ST_UPIR  = 4'hD, ST_CAPIR = 4'hE, ST_TLR   = 4'hF
    } tap_state_e;

    tap_state_e                 state, state_nxt;
    logic [IR_WIDTH-1:0]        ir_sh, ir_reg;
    logic                       byp;
    logic [31:0]                id_sh;
    logic [USER_DR_WIDTH-1:0]   user_sh, user_upd;
    logic                       user_stb;
    logic                       sel_id, sel_user;

    // DR selection only changes at UPIR, so it is stable across any DR scan
    assign sel_id   = (ir_reg == OPC_IDCODE);
    assign sel_user = (ir_reg == OPC_USER) && !sel_id;

    always_ff @(posedge TCK) begin
        if (TRST) state <= ST_TLR;
        else      state <= state_nxt;
    end

    always_comb begin
        state_nxt = ST_TLR;
        unique case (state)
            ST_TLR:   state_nxt = TMS ? ST_TLR   : ST_RTI;
            ST_RTI:   state_nxt = TMS ? ST_SELDR : ST_RTI;
            ST_SELDR: state_nxt = TMS ? ST_SELIR : ST_CAPDR;
            ST_CAPDR: state_nxt = TMS ? ST_EX1DR : ST_SHDR;
            ST_SHDR:  state_nxt = TMS ? ST_EX1DR : ST_SHDR;
            ST_EX1DR: state_nxt = TMS ? ST_UPDR  : ST_PADR;
            ST_PADR:  state_nxt = TMS ? ST_EX2DR : ST_PADR;
            ST_EX2DR: state_nxt = TMS ? ST_UPDR  : ST_SHDR;
            ST_UPDR:  state_nxt = TMS ? ST_SELDR : ST_RTI;
            ST_SELIR: state_nxt = TMS ? ST_TLR   : ST_CAPIR;
            ST_CAPIR: state_nxt = TMS ? ST_EX1IR : ST_SHIR;
            ST_SHIR:  state_nxt = TMS ? ST_EX1IR : ST_SHIR;
            ST_EX1IR: state_nxt = TMS ? ST_UPIR  : ST_PAIR;
            ST_PAIR:  state_nxt = TMS ? ST_EX2IR : ST_PAIR;
            ST_EX2IR: state_nxt = TMS ? ST_UPIR  : ST_SHIR;
            ST_UPIR:  state_nxt = TMS ? ST_SELDR : ST_RTI;
            default:  state_nxt = ST_TLR;
        endcase
    end

    // Instruction path: capture 2'b01 pattern, shift LSB out, commit at UPIR
    always_ff @(posedge TCK) begin
        if (TRST) begin
            ir_sh  <= '0;
            ir_reg <= OPC_IDCODE;
        end else begin
            case (state)
                ST_TLR:   ir_reg <= OPC_IDCODE;
                ST_CAPIR: ir_sh  <= IR_WIDTH'(2'b01);
                ST_SHIR:  ir_sh  <= (ir_sh >> 1) | (IR_WIDTH'(TDI) << (IR_WIDTH - 1));
                ST_UPIR:  ir_reg <= ir_sh;
                default:  ;
            endcase
        end
    end

    // Data registers: only the selected one captures/shifts
    always_ff @(posedge TCK) begin
        if (TRST) begin
            byp     <= 1'b0;
            id_sh   <= '0;
            user_sh <= '0;
        end else if (state == ST_CAPDR) begin
            if (sel_id)        id_sh   <= IDCODE_VALUE;
            else if (sel_user) user_sh <= USER_CAPTURE;
            else               byp     <= 1'b0;
        end else if (state == ST_SHDR) begin
            if (sel_id)        id_sh   <= {TDI, id_sh[31:1]};
            else if (sel_user) user_sh <= (user_sh >> 1) |
                                          (USER_DR_WIDTH'(TDI) << (USER_DR_WIDTH - 1));
            else               byp     <= TDI;
        end
    end

    // Strobe is high for the single cycle following the UPDR edge
    always_ff @(posedge TCK) begin
        if (TRST) begin
            user_upd <= '0;
            user_stb <= 1'b0;
        end else begin
            user_stb <= 1'b0;
            if (state == ST_UPDR && sel_user) begin
                user_upd <= user_sh;
                user_stb <= 1'b1;
            end
        end
    end

    always_comb begin
        TDO    = 1'b0;
        TDO_EN = 1'b0;
        if (state == ST_SHIR) begin
            TDO    = ir_sh[0];
            TDO_EN = 1'b1;
        end else if (state == ST_SHDR) begin
            TDO_EN = 1'b1;
            if (sel_id)        TDO = id_sh[0];
            else if (sel_user) TDO = user_sh[0];
            else               TDO = byp;
        end
    end

    assign STATE           = state;
    assign IR_OUT          = ir_reg;
    assign USER_SEL        = sel_user;
    assign USER_UPDATE     = user_upd;
    assign USER_UPDATE_STB = user_stb;
    assign TLR             = (state == ST_TLR);
    assign RTI             = (state == ST_RTI);

endmodule

// File: tb/tb_jtag_tap_core.sv
// Bench for jtag_tap_core: directed scans plus random TMS/TDI/TRST traffic
// compared every edge against a queue-based reference of the TAP.
module tb_jtag_tap_core;

    logic       TCK = 1'b0;
    logic       TRST = 1'b1, TMS = 1'b0, TDI = 1'b0;
    logic       TDO, TDO_EN, USER_SEL, USER_UPDATE_STB, TLR, RTI;
    logic [3:0] STATE, IR_OUT;
    logic [7:0] USER_CAPTURE = 8'h00, USER_UPDATE;

    jtag_tap_core dut (
        .TCK(TCK), .TRST(TRST), .TMS(TMS), .TDI(TDI), .TDO(TDO), .TDO_EN(TDO_EN),
        .STATE(STATE), .IR_OUT(IR_OUT), .USER_SEL(USER_SEL),
        .USER_CAPTURE(USER_CAPTURE), .USER_UPDATE(USER_UPDATE),
        .USER_UPDATE_STB(USER_UPDATE_STB), .TLR(TLR), .RTI(RTI)
    );

    always #5 TCK = ~TCK;

    // Standard 1149.1 successor table, indexed by state code
    localparam logic [3:0] NXT0 [16] = '{4'h2, 4'h3, 4'h2, 4'h3, 4'hE, 4'hC, 4'h2, 4'h6,
                                         4'hA, 4'hB, 4'hA, 4'hB, 4'hC, 4'hC, 4'hA, 4'hC};
    localparam logic [3:0] NXT1 [16] = '{4'h5, 4'h5, 4'h1, 4'h0, 4'hF, 4'h7, 4'h1, 4'h4,
                                         4'hD, 4'hD, 4'h9, 4'h8, 4'h7, 4'h7, 4'h9, 4'hF};

    int n_chk = 0, n_err = 0;

    logic [3:0] m_st, m_ir;
    logic [7:0] m_upd;
    bit         m_stb;
    bit         irq[$];   // element 0 is the bit presented on TDO
    bit         drq[$];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] pack(input bit q[$]);
        logic [31:0] v = '0;
        foreach (q[i]) v[i] = q[i];
        return v;
    endfunction

    task automatic model_edge(input bit trst, input bit tms, input bit tdi, input logic [7:0] cap);
        logic [3:0] ns;
        if (trst) begin
            m_st = 4'hF; m_ir = 4'h1; m_upd = 8'h00; m_stb = 0;
            irq = '{0, 0, 0, 0};
            drq.delete();
            return;
        end
        ns = tms ? NXT1[m_st] : NXT0[m_st];
        m_stb = 0;
        if (m_st == 4'hF) m_ir = 4'h1;
        else if (m_st == 4'hE) irq = '{1, 0, 0, 0};
        else if (m_st == 4'hA) begin void'(irq.pop_front()); irq.push_back(tdi); end
        else if (m_st == 4'hD) m_ir = pack(irq);
        else if (m_st == 4'h6) begin
            drq.delete();
            if (m_ir == 4'h1)      for (int i = 0; i < 32; i++) drq.push_back(32'h1234_5001 >> i & 1);
            else if (m_ir == 4'h2) for (int i = 0; i < 8; i++)  drq.push_back(cap[i]);
            else                   drq.push_back(0);
        end
        else if (m_st == 4'h2) begin void'(drq.pop_front()); drq.push_back(tdi); end
        else if (m_st == 4'h5 && m_ir == 4'h2) begin
            m_upd = pack(drq);
            m_stb = 1;
        end
        m_st = ns;
    endtask

    task automatic compare_all();
        bit etdo;
        etdo = 0;
        if (m_st == 4'hA) etdo = irq[0];
        else if (m_st == 4'h2 && drq.size() > 0) etdo = drq[0];
        chk("state", STATE, m_st);
        chk("ir_out", IR_OUT, m_ir);
        chk("tdo", TDO, etdo);
        chk("tdo_en", TDO_EN, (m_st == 4'hA || m_st == 4'h2));
        chk("user_sel", USER_SEL, (m_ir == 4'h2));
        chk("user_update", USER_UPDATE, m_upd);
        chk("stb", USER_UPDATE_STB, m_stb);
        chk("tlr", TLR, (m_st == 4'hF));
        chk("rti", RTI, (m_st == 4'hC));
    endtask

    task automatic tick(input bit tms, input bit tdi, input bit trst = 0);
        TMS = tms; TDI = tdi; TRST = trst;
        @(posedge TCK);
        model_edge(trst, tms, tdi, USER_CAPTURE);
        #1;
        compare_all();
    endtask

    // From RTI: load an instruction and return to RTI
    task automatic load_ir(input logic [3:0] v);
        tick(1, 0); tick(1, 0); tick(0, 0); tick(0, 0);
        for (int i = 0; i < 4; i++) tick(i == 3, v[i]);
        tick(1, 0); tick(0, 0);
    endtask

    initial begin
        logic [31:0] val;
        bit          en_all;
        logic [7:0]  pat;

        // Reset state
        tick(0, 0, 1);
        chk("rst_state", STATE, 4'hF);
        chk("rst_ir", IR_OUT, 4'h1);

        // IDCODE readout
        tick(0, 0); tick(1, 0); tick(0, 0); tick(0, 0);
        val = 0; en_all = 1;
        for (int i = 0; i < 32; i++) begin
            val[i] = TDO;
            en_all &= TDO_EN;
            tick(i == 31, 0);
        end
        chk("t1_idcode", val, 32'h1234_5001);
        chk("t1_en", en_all, 1);
        tick(1, 0); tick(0, 0);

        // IR capture pattern, then load all-ones
        tick(1, 0); tick(1, 0); tick(0, 0); tick(0, 0);
        val = 0;
        for (int i = 0; i < 4; i++) begin val[i] = TDO; tick(i == 3, 1); end
        chk("t2_ircap", val, 32'h1);
        tick(1, 0); tick(0, 0);
        chk("t2_ir", IR_OUT, 4'hF);

        // BYPASS one-bit delay
        tick(1, 0); tick(0, 0); tick(0, 0);
        pat = 8'b1101;  // TDI 1,0,1,1 LSB first
        val = 0;
        for (int i = 0; i < 4; i++) begin val[i] = TDO; tick(i == 3, pat[i]); end
        chk("t3_bypass", val, 32'hA);  // TDO 0,1,0,1
        tick(1, 0); tick(0, 0);

        // USER capture/update
        load_ir(4'h2);
        chk("t4_sel", USER_SEL, 1);
        USER_CAPTURE = 8'hA5;
        tick(1, 0); tick(0, 0); tick(0, 0);
        pat = 8'h3C; val = 0;
        for (int i = 0; i < 8; i++) begin val[i] = TDO; tick(i == 7, pat[i]); end
        chk("t4_capture", val, 32'hA5);
        tick(1, 0);
        chk("t4_nostb_early", USER_UPDATE_STB, 0);
        tick(0, 0);
        chk("t4_update", USER_UPDATE, 8'h3C);
        chk("t4_stb", USER_UPDATE_STB, 1);
        tick(0, 0);
        chk("t4_stb_drop", USER_UPDATE_STB, 0);

        // Reset mid-shift abandons the scan
        tick(1, 0); tick(0, 0); tick(0, 0);
        tick(0, 1); tick(0, 1); tick(0, 1);
        tick(0, 0, 1);
        chk("t5_state", STATE, 4'hF);
        chk("t5_ir", IR_OUT, 4'h1);
        chk("t5_stb", USER_UPDATE_STB, 0);
        chk("t5_upd_clr", USER_UPDATE, 8'h00);
        // Five TMS=1 edges from SHIR reach TLR; next TLR edge restores IDCODE
        tick(0, 0); tick(1, 0); tick(1, 0); tick(0, 0); tick(0, 0);
        for (int i = 0; i < 5; i++) tick(1, 0);
        chk("t5_tms5", STATE, 4'hF);
        tick(1, 0);
        chk("t5_ir_tlr", IR_OUT, 4'h1);

        // Pause/resume without re-capture
        tick(0, 0);
        load_ir(4'h2);
        USER_CAPTURE = 8'($urandom);
        pat = 8'($urandom);
        tick(1, 0); tick(0, 0); tick(0, 0);
        for (int i = 0; i < 3; i++) tick(i == 2, pat[i]);
        tick(0, 0);
        USER_CAPTURE = ~USER_CAPTURE;
        for (int i = 0; i < 4; i++) tick(0, 0);
        tick(1, 0); tick(0, 0);
        for (int i = 3; i < 8; i++) tick(i == 7, pat[i]);
        tick(1, 0); tick(0, 0);
        chk("t6_update", USER_UPDATE, pat);

        // Random traffic
        for (int n = 0; n < 3000; n++) begin
            USER_CAPTURE = 8'($urandom);
            tick(($urandom_range(0, 99) < 45), 1'($urandom), ($urandom_range(0, 199) == 0));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
